mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the MIPS core; sits directly upstream of the register file.
- Fetches an instruction over a req/valid handshake, decodes it, and drives rs/rt/rd/we to the register file.
- Drives ALU select and data-memory handshake signals; owns the PC.
- Register file: 16 entries, write on negedge clk, read outputs regA/regB registered on posedge clk. Sequencing below is built around that timing.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- NUM_REGS, 16, implemented register count; any register field >= NUM_REGS is illegal.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- instr_req  out  1  instruction fetch request.
- pc  out  32  fetch address.
- instr_valid  in  1  instr_data valid; accepted only in FETCH.
- instr_data  in  32  fetched instruction.
- rs  out  5  register file read port A index.
- rt  out  5  register file read port B index.
- rd  out  5  register file write index.
- we  out  1  register file write enable.
- wb_sel  out  1  write-back source: 0 = ALU result, 1 = memory read data.
- imm  out  32  sign-extended IR[15:0].
- alu_src_imm  out  1  ALU operand B: 1 = imm, 0 = regB.
- alu_op  out  3  ALU operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT.
- alu_zero  in  1  ALU result == 0; sampled in EXEC only.
- mem_req  out  1  data memory request.
- mem_we  out  1  data memory write (SW).
- mem_ready  in  1  data memory done; sampled in MEM only.
- illegal  out  1  sticky trap flag.
- state  out  3  current state, for debug.

Behaviour:
- Reset (async, immediate):
  - state = FETCH (0), pc = PC_RESET.
  - IR, rs, rt, rd, imm, alu_op = 0.
  - we, wb_sel, alu_src_imm, mem_req, mem_we, illegal = 0.
  - Reset mid-operation aborts the instruction; we and mem_req drop without waiting for a clock.
- All outputs are registered or decoded from state plus IR; no combinational path from any input to any output.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH:
  - instr_req=1.
  - On a posedge with instr_valid=1: IR <= instr_data, pc <= pc+4, rs <= instr_data[25:21], rt <= instr_data[20:16], go DECODE.
  - Otherwise hold; no timeout.
- DECODE (exactly 1 cycle): register file latches regA/regB at the posedge ending this state.
  - imm = {{16{IR[15]}}, IR[15:0]}.
  - Supported opcodes:
    - 0x00 R-type, funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT.
    - 0x08 ADDI, 0x23 LW, 0x2B SW, 0x04 BEQ, 0x02 J.
  - Any other opcode/funct, or any used register field >= NUM_REGS -> TRAP.
  - J: pc <= {pc[31:28], IR[25:0], 2'b00}, go FETCH.
  - All other supported instructions -> EXEC.
- EXEC (1 cycle): alu_op and alu_src_imm valid; regA/regB are valid this cycle.
  - alu_src_imm=1 for ADDI/LW/SW.
  - alu_op: SUB for BEQ, ADD for ADDI/LW/SW, per funct for R-type.
  - BEQ: if alu_zero, pc <= pc + (imm<<2) (pc already incremented, 32-bit wrap); go FETCH.
  - R-type/ADDI -> WB. LW/SW -> MEM.
- MEM:
  - mem_req=1; mem_we=1 for SW only.
  - Hold until mem_ready=1 at a posedge; then LW -> WB, SW -> FETCH.
  - mem_req deasserts the cycle after the acknowledge.
- WB (1 cycle):
  - rd = IR[15:11] for R-type, IR[20:16] otherwise.
  - wb_sel=1 for LW only.
  - we=1 exactly this cycle; the register file writes at the mid-cycle negedge.
  - we forced 0 when rd==0 (r0 read-only).
  - Next state: FETCH.
- TRAP: illegal=1, all request/enable outputs 0, leave only by rst.
- Ignored inputs: instr_valid outside FETCH; mem_ready and alu_zero outside their states.
- Cycle counts, excluding handshake waits: J 2; BEQ 3; R-type/ADDI 4; SW 4; LW 5.

Test Plan:
- Reset with PC_RESET=0: release rst -> pc=0, instr_req=1, state=0, we=0. Assert rst mid-MEM -> mem_req=0 at once, state=0.
- Fetch ADD r3,r1,r2 (0x00221820), instr_valid held 1 -> rs=1, rt=2 in DECODE; alu_op=0 in EXEC; WB has rd=3, we=1 for one cycle; pc=4; 4 cycles total.
- LW r5,8(r2) (0x8C450008), mem_ready delayed 3 cycles -> mem_req high 3 cycles, mem_we=0, imm=8; WB has rd=5, wb_sel=1, we=1.
- BEQ at pc=0x10, imm=-2:
  - with alu_zero=1 in EXEC -> pc=0x0C;
  - with alu_zero=0 -> pc=0x14;
  - we never asserted.
- J 0x0000040 (0x08000040) -> pc=0x100 after DECODE, back in FETCH.
- Illegal cases:
  - opcode 0x3F -> TRAP, illegal=1, instr_req=0, and it stays so for 20 cycles;
  - ADD r20,r1,r2 -> TRAP;
  - ADDI r0,r1,5 -> WB with we=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/decode/exec/mem/wb sequencing,
// PC ownership and register-file / ALU / data-memory control.
module mips_multicycle_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          NUM_REGS = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        instr_req,
  output logic [31:0] pc,
  input  logic        instr_valid,
  input  logic [31:0] instr_data,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic        we,
  output logic        wb_sel,
  output logic [31:0] imm,
  output logic        alu_src_imm,
  output logic [2:0]  alu_op,
  input  logic        alu_zero,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        illegal,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [5:0] W_NREGS = 6'(NUM_REGS);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        r_instr_req;
  logic        r_we;
  logic        r_wb_sel;
  logic        r_mem_req;
  logic        r_mem_we;
  logic        r_illegal;

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic        w_is_r;
  logic        w_is_j;
  logic        w_is_beq;
  logic        w_is_addi;
  logic        w_is_lw;
  logic        w_is_sw;
  logic        w_fn_ok;
  logic        w_rs_bad;
  logic        w_rt_bad;
  logic        w_rd_bad;
  logic        w_legal;
  logic [2:0]  w_alu_op;
  logic [4:0]  w_rd;
  logic [31:0] w_imm;
  logic [31:0] w_jtarget;
  logic [31:0] w_btarget;

  assign w_op      = r_ir[31:26];
  assign w_funct   = r_ir[5:0];
  assign w_is_r    = (w_op == OP_R);
  assign w_is_j    = (w_op == OP_J);
  assign w_is_beq  = (w_op == OP_BEQ);
  assign w_is_addi = (w_op == OP_ADDI);
  assign w_is_lw   = (w_op == OP_LW);
  assign w_is_sw   = (w_op == OP_SW);

  assign w_rs_bad = ({1'b0, r_ir[25:21]} >= W_NREGS);
  assign w_rt_bad = ({1'b0, r_ir[20:16]} >= W_NREGS);
  assign w_rd_bad = ({1'b0, r_ir[15:11]} >= W_NREGS);

  assign w_imm     = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_rd      = w_is_r ? r_ir[15:11] : r_ir[20:16];
  assign w_jtarget = {r_pc[31:28], r_ir[25:0], 2'b00};
  assign w_btarget = r_pc + {w_imm[29:0], 2'b00};

  always_comb begin
    w_fn_ok  = 1'b0;
    w_alu_op = ALU_ADD;
    if (w_is_beq) begin
      w_alu_op = ALU_SUB;
    end else if (w_is_r) begin
      unique case (w_funct)
        FN_ADD: begin w_fn_ok = 1'b1; w_alu_op = ALU_ADD; end
        FN_SUB: begin w_fn_ok = 1'b1; w_alu_op = ALU_SUB; end
        FN_AND: begin w_fn_ok = 1'b1; w_alu_op = ALU_AND; end
        FN_OR:  begin w_fn_ok = 1'b1; w_alu_op = ALU_OR;  end
        FN_SLT: begin w_fn_ok = 1'b1; w_alu_op = ALU_SLT; end
        default: begin w_fn_ok = 1'b0; w_alu_op = ALU_ADD; end
      endcase
    end
  end

  // J uses no register fields; I-types use rs/rt, R-types add rd
  assign w_legal =
    (w_is_r & w_fn_ok & ~w_rs_bad & ~w_rt_bad & ~w_rd_bad) |
    ((w_is_addi | w_is_lw | w_is_sw | w_is_beq) & ~w_rs_bad & ~w_rt_bad) |
    w_is_j;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH:  w_next = instr_valid ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!w_legal)    w_next = S_TRAP;
        else if (w_is_j) w_next = S_FETCH;
        else             w_next = S_EXEC;
      end
      S_EXEC: begin
        if (w_is_beq)              w_next = S_FETCH;
        else if (w_is_lw | w_is_sw) w_next = S_MEM;
        else                       w_next = S_WB;
      end
      S_MEM: begin
        if (mem_ready) w_next = w_is_lw ? S_WB : S_FETCH;
      end
      S_WB:     w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= PC_RESET;
      r_ir        <= '0;
      r_instr_req <= 1'b1;
      r_we        <= 1'b0;
      r_wb_sel    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && instr_valid) begin
        r_ir <= instr_data;
        r_pc <= r_pc + 32'd4;
      end else if (r_state == S_DECODE && w_is_j) begin
        r_pc <= w_jtarget;
      end else if (r_state == S_EXEC && w_is_beq && alu_zero) begin
        r_pc <= w_btarget;
      end
      // strobes are computed from the next state so they line up with it
      r_instr_req <= (w_next == S_FETCH);
      r_mem_req   <= (w_next == S_MEM);
      r_mem_we    <= (w_next == S_MEM) && w_is_sw;
      r_we        <= (w_next == S_WB) && (w_rd != 5'd0);
      r_wb_sel    <= (w_next == S_WB) && w_is_lw;
      r_illegal   <= (w_next == S_TRAP);
    end
  end

  assign instr_req   = r_instr_req;
  assign pc          = r_pc;
  assign rs          = r_ir[25:21];
  assign rt          = r_ir[20:16];
  assign rd          = w_rd;
  assign we          = r_we;
  assign wb_sel      = r_wb_sel;
  assign imm         = w_imm;
  assign alu_src_imm = w_is_addi | w_is_lw | w_is_sw;
  assign alu_op      = w_alu_op;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign illegal     = r_illegal;
  assign state       = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: instruction table plus
// hand-written reset-abort and trap sequences.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req;
  logic [31:0] pc;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        we;
  logic        wb_sel;
  logic [31:0] imm;
  logic        alu_src_imm;
  logic [2:0]  alu_op;
  logic        alu_zero;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ready;
  logic        illegal;
  logic [2:0]  state;

  int n_chk = 0;
  int n_err = 0;

  mips_multicycle_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr_req   (instr_req),
    .pc          (pc),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .we          (we),
    .wb_sel      (wb_sel),
    .imm         (imm),
    .alu_src_imm (alu_src_imm),
    .alu_op      (alu_op),
    .alu_zero    (alu_zero),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_ready   (mem_ready),
    .illegal     (illegal),
    .state       (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    int          dly;
    int          cyc;
    logic [31:0] pc;
    int          we_n;
    logic [4:0]  rd;
    logic        wbsel;
    logic [2:0]  aop;
    logic        src;
    int          mreq_n;
    int          mwe_n;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] imm;
  } vec_t;

  vec_t tbl[$];
  vec_t o;
  int   n;
  int   bad;

  function automatic vec_t mk(
    input logic [31:0] instr, input logic zero, input int dly,
    input int cyc, input logic [31:0] pc_e, input int we_n,
    input logic [4:0] rd_e, input logic wbsel, input logic [2:0] aop,
    input logic src, input int mreq_n, input int mwe_n,
    input logic [4:0] rs_e, input logic [4:0] rt_e,
    input logic [31:0] imm_e);
    vec_t v;
    v.instr = instr; v.zero = zero; v.dly = dly;
    v.cyc = cyc; v.pc = pc_e; v.we_n = we_n;
    v.rd = rd_e; v.wbsel = wbsel; v.aop = aop;
    v.src = src; v.mreq_n = mreq_n; v.mwe_n = mwe_n;
    v.rs = rs_e; v.rt = rt_e; v.imm = imm_e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Starts at a negedge in FETCH, ends at a negedge back in FETCH or TRAP
  task automatic run(input vec_t v, output vec_t r);
    int mcnt;
    r = v;
    r.cyc = 0; r.we_n = 0; r.rd = '0; r.wbsel = 1'b0;
    r.aop = '0; r.src = 1'b0; r.mreq_n = 0; r.mwe_n = 0;
    r.rs = '0; r.rt = '0; r.imm = '0; r.pc = '0;
    mcnt = 0;
    instr_data  = v.instr;
    instr_valid = 1'b1;
    alu_zero    = v.zero;
    mem_ready   = 1'b0;
    do begin
      @(posedge clk);
      r.cyc++;
      @(negedge clk);
      instr_valid = 1'b0;
      if (we)      r.we_n++;
      if (mem_req) r.mreq_n++;
      if (mem_we)  r.mwe_n++;
      case (state)
        3'd1: begin r.rs = rs; r.rt = rt; r.imm = imm; end
        3'd2: begin r.aop = alu_op; r.src = alu_src_imm; end
        3'd3: begin mcnt++; mem_ready = (mcnt >= v.dly); end
        3'd4: begin r.rd = rd; r.wbsel = wb_sel; end
        default: ;
      endcase
      if (state != 3'd3) mem_ready = 1'b0;
    end while (state != 3'd0 && state != 3'd5 && r.cyc < 40);
    r.pc = pc;
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr_data = '0;
    alu_zero = 1'b0; mem_ready = 1'b0;

    //           instr        z  dly cyc pc         we rd     wb    aop   src mq mw rs     rt     imm
    tbl.push_back(mk(32'h00221820, 1'b0, 1, 4, 32'h04,  1, 5'd3, 1'b0, 3'd0, 1'b0, 0, 0, 5'd1, 5'd2, 32'h1820));
    tbl.push_back(mk(32'h00222022, 1'b0, 1, 4, 32'h08,  1, 5'd4, 1'b0, 3'd1, 1'b0, 0, 0, 5'd1, 5'd2, 32'h2022));
    tbl.push_back(mk(32'h00C72824, 1'b0, 1, 4, 32'h0C,  1, 5'd5, 1'b0, 3'd2, 1'b0, 0, 0, 5'd6, 5'd7, 32'h2824));
    tbl.push_back(mk(32'h00224025, 1'b0, 1, 4, 32'h10,  1, 5'd8, 1'b0, 3'd3, 1'b0, 0, 0, 5'd1, 5'd2, 32'h4025));
    tbl.push_back(mk(32'h0022482A, 1'b0, 1, 4, 32'h14,  1, 5'd9, 1'b0, 3'd4, 1'b0, 0, 0, 5'd1, 5'd2, 32'h482A));
    tbl.push_back(mk(32'h20270005, 1'b0, 1, 4, 32'h18,  1, 5'd7, 1'b0, 3'd0, 1'b1, 0, 0, 5'd1, 5'd7, 32'h5));
    tbl.push_back(mk(32'h8C450008, 1'b0, 1, 5, 32'h1C,  1, 5'd5, 1'b1, 3'd0, 1'b1, 1, 0, 5'd2, 5'd5, 32'h8));
    tbl.push_back(mk(32'h8C450008, 1'b0, 3, 7, 32'h20,  1, 5'd5, 1'b1, 3'd0, 1'b1, 3, 0, 5'd2, 5'd5, 32'h8));
    tbl.push_back(mk(32'hAC450008, 1'b0, 1, 4, 32'h24,  0, 5'd0, 1'b0, 3'd0, 1'b1, 1, 1, 5'd2, 5'd5, 32'h8));
    tbl.push_back(mk(32'hAC450008, 1'b0, 2, 5, 32'h28,  0, 5'd0, 1'b0, 3'd0, 1'b1, 2, 2, 5'd2, 5'd5, 32'h8));
    tbl.push_back(mk(32'h20200005, 1'b0, 1, 4, 32'h2C,  0, 5'd0, 1'b0, 3'd0, 1'b1, 0, 0, 5'd1, 5'd0, 32'h5));
    tbl.push_back(mk(32'h1022FFFE, 1'b0, 1, 3, 32'h30,  0, 5'd0, 1'b0, 3'd1, 1'b0, 0, 0, 5'd1, 5'd2, 32'hFFFFFFFE));
    tbl.push_back(mk(32'h1022FFFE, 1'b1, 1, 3, 32'h2C,  0, 5'd0, 1'b0, 3'd1, 1'b0, 0, 0, 5'd1, 5'd2, 32'hFFFFFFFE));
    tbl.push_back(mk(32'h08000040, 1'b0, 1, 2, 32'h100, 0, 5'd0, 1'b0, 3'd0, 1'b0, 0, 0, 5'd0, 5'd0, 32'h40));
    tbl.push_back(mk(32'h08000004, 1'b0, 1, 2, 32'h10,  0, 5'd0, 1'b0, 3'd0, 1'b0, 0, 0, 5'd0, 5'd0, 32'h4));
    tbl.push_back(mk(32'h1022FFFE, 1'b1, 1, 3, 32'h0C,  0, 5'd0, 1'b0, 3'd1, 1'b0, 0, 0, 5'd1, 5'd2, 32'hFFFFFFFE));
    tbl.push_back(mk(32'h08000004, 1'b0, 1, 2, 32'h10,  0, 5'd0, 1'b0, 3'd0, 1'b0, 0, 0, 5'd0, 5'd0, 32'h4));
    tbl.push_back(mk(32'h1022FFFE, 1'b0, 1, 3, 32'h14,  0, 5'd0, 1'b0, 3'd1, 1'b0, 0, 0, 5'd1, 5'd2, 32'hFFFFFFFE));

    repeat (2) @(posedge clk);
    #1;
    chk("in_rst state", 32'(state), 32'd0);
    chk("in_rst mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst pc", pc, 32'h0);
    chk("rst instr_req", 32'(instr_req), 32'd1);
    chk("rst state", 32'(state), 32'd0);
    chk("rst we", 32'(we), 32'd0);
    chk("rst illegal", 32'(illegal), 32'd0);
    chk("rst imm", imm, 32'h0);
    chk("rst alu_op", 32'(alu_op), 32'd0);
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      run(tbl[i], o);
      chk($sformatf("v%0d cycles", i), 32'(o.cyc), 32'(tbl[i].cyc));
      chk($sformatf("v%0d pc", i), o.pc, tbl[i].pc);
      chk($sformatf("v%0d we_cycles", i), 32'(o.we_n), 32'(tbl[i].we_n));
      chk($sformatf("v%0d rd", i), 32'(o.rd), 32'(tbl[i].rd));
      chk($sformatf("v%0d wb_sel", i), 32'(o.wbsel), 32'(tbl[i].wbsel));
      chk($sformatf("v%0d alu_op", i), 32'(o.aop), 32'(tbl[i].aop));
      chk($sformatf("v%0d alu_src_imm", i), 32'(o.src), 32'(tbl[i].src));
      chk($sformatf("v%0d mem_req_cycles", i), 32'(o.mreq_n), 32'(tbl[i].mreq_n));
      chk($sformatf("v%0d mem_we_cycles", i), 32'(o.mwe_n), 32'(tbl[i].mwe_n));
      chk($sformatf("v%0d rs", i), 32'(o.rs), 32'(tbl[i].rs));
      chk($sformatf("v%0d rt", i), 32'(o.rt), 32'(tbl[i].rt));
      chk($sformatf("v%0d imm", i), o.imm, tbl[i].imm);
      chk($sformatf("v%0d end_state", i), 32'(state), 32'd0);
    end

    // Reset in the middle of a stalled SW
    instr_data = 32'hAC450008; instr_valid = 1'b1; mem_ready = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      n++;
    end while (state != 3'd3 && n < 10);
    chk("mid_mem state", 32'(state), 32'd3);
    chk("mid_mem mem_req", 32'(mem_req), 32'd1);
    chk("mid_mem mem_we", 32'(mem_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort mem_req", 32'(mem_req), 32'd0);
    chk("abort mem_we", 32'(mem_we), 32'd0);
    chk("abort state", 32'(state), 32'd0);
    chk("abort pc", pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Unsupported opcode traps and stays trapped
    instr_data = 32'hFC000000; instr_valid = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    chk("op3f state", 32'(state), 32'd5);
    chk("op3f illegal", 32'(illegal), 32'd1);
    chk("op3f instr_req", 32'(instr_req), 32'd0);
    chk("op3f pc", pc, 32'h4);
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (state != 3'd5 || !illegal || instr_req || mem_req || we) bad++;
    end
    chk("op3f sticky_bad_cycles", 32'(bad), 32'd0);
    chk("op3f pc_held", pc, 32'h4);
    instr_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("trap_rst illegal", 32'(illegal), 32'd0);
    chk("trap_rst instr_req", 32'(instr_req), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // rd field out of range traps
    instr_data = 32'h0022A020; instr_valid = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    instr_valid = 1'b0;
    chk("add_r20 state", 32'(state), 32'd5);
    chk("add_r20 illegal", 32'(illegal), 32'd1);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Normal operation resumes after reset
    run(tbl[0], o);
    chk("post_trap cycles", 32'(o.cyc), 32'd4);
    chk("post_trap pc", o.pc, 32'h4);
    chk("post_trap we_cycles", 32'(o.we_n), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
